// File: rtl/fx2_pkg.sv
// Shared constants and the FIFO entry type for the FX2 slave-FIFO model.
package fx2_pkg;

    localparam logic [1:0] FIFOADR_EP2 = 2'b00;
    localparam logic [1:0] FIFOADR_EP4 = 2'b01;
    localparam logic [1:0] FIFOADR_EP6 = 2'b10;
    localparam logic [1:0] FIFOADR_EP8 = 2'b11;

    localparam int FLAG_EP2_AVAIL = 0;
    localparam int FLAG_EP6_NFULL = 1;
    localparam int FLAG_EP8_NFULL = 2;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fx2_entry_t;

endpackage

// File: rtl/fx2_ep_fifo.sv
// First-word-fall-through endpoint FIFO with write, commit and read pointers.
// Optional FX2_AUTOPKT_EN commits automatically once PKT_SIZE bytes are pending.
module fx2_ep_fifo
    import fx2_pkg::*;
#(
    parameter int DEPTH_LOG2    = 9,
    parameter int PKT_SIZE      = 512,
    parameter bit WRITE_COMMITS = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic       rd_en,
    output fx2_entry_t rd_entry,
    output logic       full,
    output logic       empty,
    output logic       zlp
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef logic [DEPTH_LOG2:0]   ptr_t;
    typedef logic [DEPTH_LOG2-1:0] idx_t;

    ptr_t wr_q, cm_q, rd_q;
    ptr_t wr_d, cm_d, rd_d;
    ptr_t pending;
    logic [7:0]       mem [DEPTH];
    logic [DEPTH-1:0] last_q;
    logic push, pop, pkt_hit, auto_hit, do_commit, zlp_q;
    idx_t wr_idx, rd_idx, prev_idx;

    assign wr_idx   = wr_q[DEPTH_LOG2-1:0];
    assign rd_idx   = rd_q[DEPTH_LOG2-1:0];
    assign prev_idx = wr_idx - idx_t'(1);

    assign pending = wr_q - cm_q;
    assign full    = (wr_q - rd_q) == ptr_t'(DEPTH);
    assign empty   = rd_q == cm_q;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign pkt_hit = commit && !WRITE_COMMITS;

`ifdef FX2_AUTOPKT_EN
    assign auto_hit = !WRITE_COMMITS && push && ((pending + ptr_t'(1)) == ptr_t'(PKT_SIZE));
`else
    assign auto_hit = 1'b0;
    wire [31:0] unused_pkt_size = PKT_SIZE;
`endif

    // A same-cycle write joins the packet being committed and takes the last flag itself.
    assign do_commit = WRITE_COMMITS ? push
                                     : ((pkt_hit && (push || pending != '0)) || auto_hit);

    assign wr_d = wr_q + ptr_t'(push);
    assign rd_d = rd_q + ptr_t'(pop);
    assign cm_d = do_commit ? wr_d : cm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            cm_q  <= '0;
            rd_q  <= '0;
            zlp_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            cm_q  <= cm_d;
            rd_q  <= rd_d;
            zlp_q <= pkt_hit && !push && pending == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx]    <= wr_data;
            last_q[wr_idx] <= do_commit && !WRITE_COMMITS;
        end else if (pkt_hit && pending != '0) begin
            last_q[prev_idx] <= 1'b1;
        end
    end

    assign rd_entry = '{last: last_q[rd_idx], data: mem[rd_idx]};
    assign zlp      = zlp_q;

endmodule

// File: rtl/fx2_slave_fifo.sv
// FX2 chip side of the slave-FIFO interface: EP2 OUT fed by the host, EP6/EP8 IN drained by it.
// Build option: define FX2_AUTOPKT_EN to auto-commit IN packets of PKT_SIZE bytes.
module fx2_slave_fifo
    import fx2_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int PKT_SIZE   = 512
) (
    input  logic       fx2_clk,
    input  logic       reset,
    inout  wire  [7:0] fx2_fd,
    input  logic       fx2_slrd,
    input  logic       fx2_slwr,
    input  logic       fx2_sloe,
    input  logic [1:0] fx2_fifoadr,
    input  logic       fx2_pktend,
    input  logic       fx2_wu2,
    output logic [2:0] fx2_flags,
    input  logic [7:0] host_wdata,
    input  logic       host_wvalid,
    output logic       host_wready,
    output logic [7:0] ep6_rdata,
    output logic       ep6_rvalid,
    input  logic       ep6_rready,
    output logic       ep6_rlast,
    output logic       ep6_zlp,
    output logic [7:0] ep8_rdata,
    output logic       ep8_rvalid,
    input  logic       ep8_rready,
    output logic       ep8_rlast,
    output logic       ep8_zlp,
    output logic       err_ovf,
    output logic       err_unf,
    output logic       err_bus
);

    fx2_entry_t ep2_entry;
    logic ep2_full, ep2_empty, ep2_zlp, ep2_rd;
    logic [1:0] in_wr, in_commit, in_rready, in_full, in_empty, in_zlp;
    fx2_entry_t in_entry [2];
    logic err_ovf_q, err_unf_q, err_bus_q;
    logic ovf_hit, unf_hit, bus_hit;

    assign ep2_rd      = !fx2_slrd && fx2_fifoadr == FIFOADR_EP2;
    assign host_wready = !ep2_full;

    fx2_ep_fifo #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .PKT_SIZE     (PKT_SIZE),
        .WRITE_COMMITS(1'b1)
    ) u_ep2 (
        .clk     (fx2_clk),
        .rst     (reset),
        .wr_en   (host_wvalid && host_wready),
        .wr_data (host_wdata),
        .commit  (1'b0),
        .rd_en   (ep2_rd),
        .rd_entry(ep2_entry),
        .full    (ep2_full),
        .empty   (ep2_empty),
        .zlp     (ep2_zlp)
    );

    assign in_rready = {ep8_rready, ep6_rready};

    for (genvar gi = 0; gi < 2; gi++) begin : g_in
        localparam logic [1:0] ADR = (gi == 0) ? FIFOADR_EP6 : FIFOADR_EP8;
        assign in_wr[gi]     = !fx2_slwr && fx2_fifoadr == ADR;
        assign in_commit[gi] = !fx2_pktend && fx2_fifoadr == ADR;

        fx2_ep_fifo #(
            .DEPTH_LOG2   (DEPTH_LOG2),
            .PKT_SIZE     (PKT_SIZE),
            .WRITE_COMMITS(1'b0)
        ) u_fifo (
            .clk     (fx2_clk),
            .rst     (reset),
            .wr_en   (in_wr[gi]),
            .wr_data (fx2_fd),
            .commit  (in_commit[gi]),
            .rd_en   (in_rready[gi]),
            .rd_entry(in_entry[gi]),
            .full    (in_full[gi]),
            .empty   (in_empty[gi]),
            .zlp     (in_zlp[gi])
        );
    end

    assign fx2_fd = (!fx2_sloe && fx2_fifoadr == FIFOADR_EP2) ? ep2_entry.data : 8'hzz;

    assign fx2_flags[FLAG_EP2_AVAIL] = !ep2_empty;
    assign fx2_flags[FLAG_EP6_NFULL] = !in_full[0];
    assign fx2_flags[FLAG_EP8_NFULL] = !in_full[1];

    assign ep6_rdata  = in_entry[0].data;
    assign ep6_rvalid = !in_empty[0];
    assign ep6_rlast  = !in_empty[0] && in_entry[0].last;
    assign ep6_zlp    = in_zlp[0];
    assign ep8_rdata  = in_entry[1].data;
    assign ep8_rvalid = !in_empty[1];
    assign ep8_rlast  = !in_empty[1] && in_entry[1].last;
    assign ep8_zlp    = in_zlp[1];

    assign ovf_hit = |(in_wr & in_full);
    assign unf_hit = ep2_rd && ep2_empty;
    // Strobes addressed to EP4 count as bus errors, as does SLWR while SLOE is asserted.
    assign bus_hit = (!fx2_slwr && !fx2_sloe)
                  || (fx2_fifoadr == FIFOADR_EP4 && (!fx2_slwr || !fx2_slrd || !fx2_pktend));

    always_ff @(posedge fx2_clk or posedge reset) begin
        if (reset) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            err_bus_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_q | ovf_hit;
            err_unf_q <= err_unf_q | unf_hit;
            err_bus_q <= err_bus_q | bus_hit;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;
    assign err_bus = err_bus_q;

    wire unused_ok = &{1'b0, fx2_wu2, ep2_entry.last, ep2_zlp};

endmodule
